// File: rtl/ram_burst_pkg.sv
// ram_burst_pkg
//   Shared definitions for the RAM burst controller slice: FSM state encoding,
//   default RAM geometry and the RAM port opcode values.
//   No ports.
package ram_burst_pkg;

  // Default geometry of the 128x4 single-port RAM.
  localparam int RAM_AW = 7;
  localparam int RAM_DW = 4;

  // Value driven on ram_enb: 1 writes at the clock edge, 0 reads.
  localparam logic RAM_OP_WR = 1'b1;
  localparam logic RAM_OP_RD = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RD    = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/rd_skid_buf.sv
// rd_skid_buf
//   Two-entry FIFO that absorbs RAM read data so the read stream can stall
//   without losing the beat already in flight.
//   Ports:
//     clk, rst       clock, asynchronous active-low reset (flushes the FIFO)
//     push/push_data write one entry
//     pop            remove the head entry
//     head           head entry, forced to 0 while empty
//     count          occupancy, 0..2
module rd_skid_buf #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    count
);

  logic [DW-1:0] entries [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;
  logic          do_push;
  logic          do_pop;

  // Protect the pointers against a pop while empty or a push while full.
  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [DW-1:0] entry_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          entry_q <= '0;
        end else if (do_push && (wr_ptr_q == 1'(gi))) begin
          entry_q <= push_data;
        end
      end
      assign entries[gi] = entry_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = (count_q == 2'd0) ? '0 : entries[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
//   Burst access controller and sole master of a 2**AW x DW single-port RAM.
//   Takes one write or read burst command at a time and sequences one RAM
//   access per beat. Write beats arrive on wr_*, read beats leave on rd_*;
//   the RAM's one-cycle read latency is hidden behind a 2-entry skid buffer.
//   Ports:
//     clk, rst                      clock, asynchronous active-low reset
//     cmd_valid/ready/wr/addr/len   burst command (len = beats - 1)
//     wr_valid/ready/data           write beat stream
//     rd_valid/ready/data           read beat stream, full backpressure
//     busy                          burst in progress
//     err                           one-cycle pulse: command rejected
//     ram_enb/addr/w_data/r_data    RAM port (ram_r_data valid one cycle
//                                   after a read is presented)
//   Build option: define RAM_BURST_WRAP_EN to let a burst wrap from the top
//   address to 0; bounds checking and err are then removed.
module ram_burst_ctrl
  import ram_burst_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          err,
  output logic          ram_enb,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_w_data,
  input  logic [DW-1:0] ram_r_data
);

  state_e        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW-1:0] rem_q, rem_d;
  logic [AW-1:0] addr_hold_q;
  logic          inflight_q;
  logic          err_q, err_d;

  logic          wr_beat;
  logic          rd_issue;
  logic          cmd_oob;
  logic          skid_pop;
  logic [DW-1:0] skid_head;
  logic [1:0]    skid_count;
  logic [2:0]    slots_used;

`ifdef RAM_BURST_WRAP_EN
  assign cmd_oob = 1'b0;
`else
  // Carry out of the AW+1-bit sum means the burst would run past the top.
  logic [AW:0] end_addr;
  assign end_addr = {1'b0, cmd_addr} + {1'b0, cmd_len};
  assign cmd_oob  = end_addr[AW];
`endif

  assign skid_pop = (skid_count != 2'd0) && rd_ready;

  // Occupancy counted after this cycle's pop, so a read can be issued in the
  // same cycle the consumer frees a slot; this keeps 1 beat/cycle while the
  // in-flight beat plus skid contents never exceed two entries.
  assign slots_used = {1'b0, skid_count} - {2'b0, skid_pop} + {2'b0, inflight_q};

  assign wr_beat  = (state_q == ST_WR) && wr_valid;
  assign rd_issue = (state_q == ST_RD) && (slots_used < 3'd2);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    err_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_oob) begin
            err_d = 1'b1;
          end else begin
            cur_addr_d = cmd_addr;
            rem_d      = cmd_len;
            state_d    = cmd_wr ? ST_WR : ST_RD;
          end
        end
      end
      ST_WR: begin
        if (wr_beat) begin
          cur_addr_d = cur_addr_q + AW'(1);
          rem_d      = rem_q - AW'(1);
          if (rem_q == '0) state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (rd_issue) begin
          cur_addr_d = cur_addr_q + AW'(1);
          rem_d      = rem_q - AW'(1);
          if (rem_q == '0) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Nothing in flight and the skid empties at this edge.
        if (slots_used == 3'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      addr_hold_q <= '0;
      inflight_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      inflight_q <= rd_issue;
      err_q      <= err_d;
      if (wr_beat || rd_issue) addr_hold_q <= cur_addr_q;
    end
  end

  // Data returned by the read issued last cycle is captured here.
  rd_skid_buf #(.DW(DW)) u_rd_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (ram_r_data),
    .pop       (skid_pop),
    .head      (skid_head),
    .count     (skid_count)
  );

  assign cmd_ready  = (state_q == ST_IDLE);
  assign wr_ready   = (state_q == ST_WR);
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;
  assign ram_enb    = wr_beat ? RAM_OP_WR : RAM_OP_RD;
  // Between accesses the address stays on the last one presented.
  assign ram_addr   = (wr_beat || rd_issue) ? cur_addr_q : addr_hold_q;
  assign ram_w_data = wr_beat ? wr_data : '0;
  assign rd_valid   = (skid_count != 2'd0);
  assign rd_data    = skid_head;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
module tb_ram_burst_ctrl;
  import ram_burst_pkg::*;

  localparam int AW    = RAM_AW;
  localparam int DW    = RAM_DW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b1;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          err;
  logic          ram_enb;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_w_data;
  logic [DW-1:0] ram_r_data;

  always #5 clk = ~clk;

  ram_burst_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wr     (cmd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .busy       (busy),
    .err        (err),
    .ram_enb    (ram_enb),
    .ram_addr   (ram_addr),
    .ram_w_data (ram_w_data),
    .ram_r_data (ram_r_data)
  );

  // The 128x4 single-port RAM the controller drives.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_enb) ram[ram_addr] <= ram_w_data;
    else         ram_r_data    <= ram[ram_addr];
  end

  // Reference contents and scoreboards.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wbeat_t;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] rexp_q [$];
  wbeat_t        wexp_q [$];
  int            rpop_cyc [$];
  int            wr_cyc [$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  bit            err_allowed = 1'b0;
  int            rdy_mode = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Monitor: compare every RAM write and every read-stream handshake.
  logic [DW-1:0] mon_exp;
  wbeat_t        mon_wb;
  always @(negedge clk) begin
    if (rst) begin
      if (rd_valid && rd_ready) begin
        checks++;
        rpop_cyc.push_back(cyc);
        if (rexp_q.size() == 0) begin
          failures++;
          $display("FAIL rd_beat unexpected actual=%0h required=none", rd_data);
        end else begin
          mon_exp = rexp_q.pop_front();
          if (rd_data !== mon_exp) begin
            failures++;
            $display("FAIL rd_beat actual=%0h required=%0h", rd_data, mon_exp);
          end else begin
            $display("ok   rd_beat data=%0h", rd_data);
          end
        end
      end
      if (ram_enb) begin
        checks++;
        wr_cyc.push_back(cyc);
        if (wexp_q.size() == 0) begin
          failures++;
          $display("FAIL ram_wr unexpected actual=%0h@%0d required=none", ram_w_data, ram_addr);
        end else begin
          mon_wb = wexp_q.pop_front();
          if (ram_addr !== mon_wb.a || ram_w_data !== mon_wb.d) begin
            failures++;
            $display("FAIL ram_wr actual=%0h@%0d required=%0h@%0d",
                     ram_w_data, ram_addr, mon_wb.d, mon_wb.a);
          end else begin
            $display("ok   ram_wr data=%0h addr=%0d", ram_w_data, ram_addr);
          end
        end
      end
      if (err && !err_allowed) begin
        checks++;
        failures++;
        $display("FAIL err_spurious actual=1 required=0");
      end
    end
  end

  // rd_ready driver: 0 = always ready, 1 = 1,0,0,1,0,1 pattern, 2 = random.
  initial begin
    int k;
    bit pat [6];
    k = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rd_ready = 1'b1;
        1:       begin rd_ready = pat[k]; k = (k + 1) % 6; end
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"},  cmd_ready,  1);
    chk({tag, "_wr_ready"},   wr_ready,   0);
    chk({tag, "_rd_valid"},   rd_valid,   0);
    chk({tag, "_rd_data"},    rd_data,    0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_err"},        err,        0);
    chk({tag, "_ram_enb"},    ram_enb,    0);
    chk({tag, "_ram_addr"},   ram_addr,   0);
    chk({tag, "_ram_w_data"}, ram_w_data, 0);
  endtask

  // Called at posedge+1 with the block idle; returns at posedge+1 after acceptance.
  task automatic send_cmd(input bit wr, input int a, input int l);
    bit hs;
    int t;
    t = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = AW'(a);
    cmd_len   = AW'(l);
    forever begin
      @(negedge clk);
      hs = cmd_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      if (++t > 50) begin
        chk("cmd_accept_timeout", 0, 1);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d);
    bit hs;
    int t;
    t = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    forever begin
      @(negedge clk);
      hs = wr_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      if (++t > 50) begin
        chk("wr_beat_timeout", 0, 1);
        break;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy || rexp_q.size() != 0) begin
      @(posedge clk);
      #1;
      if (++t > 3000) begin
        chk({tag, "_idle_timeout"}, 0, 1);
        break;
      end
    end
    chk({tag, "_busy_after"},      busy,          0);
    chk({tag, "_cmd_ready_after"}, cmd_ready,     1);
    chk({tag, "_wr_missing"},      wexp_q.size(), 0);
    chk({tag, "_rd_missing"},      rexp_q.size(), 0);
  endtask

  // dmode: 0 random data, 1 beat index + 1, 2 low bits of the address.
  task automatic write_burst(input int a, input int l, input int dmode, input int bubble_pct);
    logic [AW-1:0] ad;
    logic [DW-1:0] d;
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= l; i++) begin
      ad = AW'(a + i);
      case (dmode)
        0:       d = DW'($urandom);
        1:       d = DW'(i + 1);
        default: d = ad[DW-1:0];
      endcase
      while ($urandom_range(0, 99) < bubble_pct) begin
        @(posedge clk);
        #1;
      end
      wexp_q.push_back({ad, d});
      ref_mem[ad] = d;
      drive_beat(d);
    end
    wait_idle("wr");
  endtask

  task automatic read_burst(input int a, input int l);
    logic [AW-1:0] ad;
    for (int i = 0; i <= l; i++) begin
      ad = AW'(a + i);
      rexp_q.push_back(ref_mem[ad]);
    end
    send_cmd(1'b0, a, l);
    wait_idle("rd");
  endtask

  task automatic bad_cmd(input int a, input int l);
    err_allowed = 1'b1;
    send_cmd(1'($urandom_range(0, 1)), a, l);
    chk("oob_err_pulse", err,       1);
    chk("oob_busy",      busy,      0);
    chk("oob_cmd_ready", cmd_ready, 1);
    chk("oob_no_ram_wr", ram_enb,   0);
    @(posedge clk);
    #1;
    chk("oob_err_clear", err, 0);
    err_allowed = 1'b0;
  endtask

  initial begin
    int a;
    int l;
    int kind;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Full depth: contents become addr[3:0] everywhere.
    rdy_mode = 0;
    write_burst(0, DEPTH - 1, 2, 0);
    read_burst(0, DEPTH - 1);

    // Directed write 10..13 with data 1..4, back-to-back.
    wr_cyc.delete();
    write_burst(10, 3, 1, 0);
    chk("wr_dir_beats", wr_cyc.size(), 4);
    if (wr_cyc.size() == 4) chk("wr_dir_consecutive", wr_cyc[3] - wr_cyc[0], 3);

    // Directed read with rd_ready high: first beat two edges after accept.
    rpop_cyc.delete();
    for (int i = 0; i < 4; i++) rexp_q.push_back(ref_mem[10 + i]);
    send_cmd(1'b0, 10, 3);
    chk("rd_lat_edge0", rd_valid, 0);
    @(posedge clk);
    #1;
    chk("rd_lat_edge1", rd_valid, 0);
    @(posedge clk);
    #1;
    chk("rd_lat_edge2", rd_valid, 1);
    wait_idle("rd_dir");
    chk("rd_dir_beats", rpop_cyc.size(), 4);
    if (rpop_cyc.size() == 4) chk("rd_dir_consecutive", rpop_cyc[3] - rpop_cyc[0], 3);

    // Backpressure pattern on the same range.
    rdy_mode = 1;
    rpop_cyc.delete();
    read_burst(10, 3);
    chk("rd_bp_beats", rpop_cyc.size(), 4);
    rdy_mode = 0;

`ifndef RAM_BURST_WRAP_EN
    bad_cmd(120, 8);
`else
    write_burst(120, 8, 1, 0);
    read_burst(120, 8);
`endif

    // Reset during beat 2 of a write at 40..45.
    send_cmd(1'b1, 40, 5);
    for (int i = 0; i < 2; i++) begin
      wexp_q.push_back({AW'(40 + i), DW'(9 + i)});
      ref_mem[40 + i] = DW'(9 + i);
      drive_beat(DW'(9 + i));
    end
    wr_valid = 1'b1;
    wr_data  = ~ref_mem[42];
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    wr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    read_burst(40, 5);

    // Randomized bursts.
    for (int n = 0; n < 40; n++) begin
      rdy_mode = $urandom_range(0, 2);
      kind = $urandom_range(0, 9);
`ifndef RAM_BURST_WRAP_EN
      if (kind == 0) begin
        a = $urandom_range(100, DEPTH - 1);
        l = $urandom_range(DEPTH - a, DEPTH - 1);
        bad_cmd(a, l);
        continue;
      end
`endif
      a = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, (DEPTH - 1 - a) < 31 ? (DEPTH - 1 - a) : 31);
      if (kind < 5) write_burst(a, l, 0, $urandom_range(0, 40));
      else          read_burst(a, l);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
